axil_rd_arb: RTL

Read-channel arbiter that shares one AXI-lite slave read port (AR/R) among S_COUNT AXI-lite masters.
- Round-robin grant; one outstanding read at a time.
- R data and response are routed back to the granted master only.
- Sits between CPU/DMA register masters and a shared AXI-lite CSR slave.

---
 rtl/axil_rd_arb_pkg.sv | 22 ++
 rtl/axil_rr_pick.sv | 35 +++
 rtl/axil_rd_arb.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/axil_rd_arb_pkg.sv
// ============================================================================
// Module : axil_rd_arb_pkg
// Brief  : State encoding and AXI response codes shared by the read arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package axil_rd_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_DATA  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

`default_nettype wire

// File: rtl/axil_rr_pick.sv
// ============================================================================
// Module : axil_rr_pick
// Brief  : Combinational round-robin picker; scans from last+1 upwards, wrapping.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axil_rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] grant,
    output logic          valid
);

    int idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!valid && req[idx]) begin
                valid = 1'b1;
                grant = IW'(idx);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/axil_rd_arb.sv
// ============================================================================
// Module : axil_rd_arb
// Brief  : Round-robin AXI-lite read arbiter, one outstanding read at a time.
//          Define AXIL_RD_ARB_TIMEOUT_EN to add a read-response timeout.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axil_rd_arb
    import axil_rd_arb_pkg::*;
#(
    parameter int S_COUNT        = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [S_COUNT*ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic [S_COUNT*3-1:0]            s_axil_arprot,
    input  logic [S_COUNT-1:0]              s_axil_arvalid,
    output logic [S_COUNT-1:0]              s_axil_arready,
    output logic [S_COUNT*DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [S_COUNT*2-1:0]            s_axil_rresp,
    output logic [S_COUNT-1:0]              s_axil_rvalid,
    input  logic [S_COUNT-1:0]              s_axil_rready,
    output logic [ADDR_WIDTH-1:0]           m_axil_araddr,
    output logic [2:0]                      m_axil_arprot,
    output logic                            m_axil_arvalid,
    input  logic                            m_axil_arready,
    input  logic [DATA_WIDTH-1:0]           m_axil_rdata,
    input  logic [1:0]                      m_axil_rresp,
    input  logic                            m_axil_rvalid,
    output logic                            m_axil_rready
);

    localparam int IW = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;

    state_t                  state_q, state_d;
    logic [IW-1:0]           last_grant_q, last_grant_d;
    logic [IW-1:0]           grant_q, grant_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [2:0]              arprot_q, arprot_d;
    logic                    arvalid_q, arvalid_d;
    logic [IW-1:0]           pick_idx;
    logic                    pick_vld;

`ifdef AXIL_RD_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    timed_out_q, timed_out_d;
`endif

    axil_rr_pick #(
        .N  (S_COUNT),
        .IW (IW)
    ) u_pick (
        .req   (s_axil_arvalid),
        .last  (last_grant_q),
        .grant (pick_idx),
        .valid (pick_vld)
    );

    assign m_axil_araddr  = araddr_q;
    assign m_axil_arprot  = arprot_q;
    assign m_axil_arvalid = arvalid_q;

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        grant_d        = grant_q;
        araddr_d       = araddr_q;
        arprot_d       = arprot_q;
        arvalid_d      = arvalid_q;
        s_axil_arready = '0;
        s_axil_rvalid  = '0;
        s_axil_rdata   = '0;
        s_axil_rresp   = '0;
        m_axil_rready  = 1'b0;
`ifdef AXIL_RD_ARB_TIMEOUT_EN
        cnt_d          = cnt_q;
        timed_out_d    = timed_out_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    s_axil_arready[pick_idx] = 1'b1;
                    grant_d   = pick_idx;
                    araddr_d  = s_axil_araddr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    arprot_d  = s_axil_arprot[int'(pick_idx)*3 +: 3];
                    arvalid_d = 1'b1;
                    state_d   = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (m_axil_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_DATA;
`ifdef AXIL_RD_ARB_TIMEOUT_EN
                    cnt_d       = '0;
                    timed_out_d = 1'b0;
`endif
                end
            end
            ST_DATA: begin
`ifdef AXIL_RD_ARB_TIMEOUT_EN
                if (timed_out_q) begin
                    // Local SLVERR held until the master takes it; the late beat is drained afterwards.
                    s_axil_rvalid[grant_q]                = 1'b1;
                    s_axil_rresp[int'(grant_q)*2 +: 2]    = RESP_SLVERR;
                    if (s_axil_rready[grant_q]) begin
                        timed_out_d  = 1'b0;
                        last_grant_d = grant_q;
                        state_d      = ST_DRAIN;
                    end
                end else begin
                    s_axil_rvalid[grant_q]                          = m_axil_rvalid;
                    s_axil_rdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH] = m_axil_rdata;
                    s_axil_rresp[int'(grant_q)*2 +: 2]              = m_axil_rresp;
                    m_axil_rready                                   = s_axil_rready[grant_q];
                    if (m_axil_rvalid && s_axil_rready[grant_q]) begin
                        last_grant_d = grant_q;
                        state_d      = ST_IDLE;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        timed_out_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`else
                s_axil_rvalid[grant_q]                               = m_axil_rvalid;
                s_axil_rdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH] = m_axil_rdata;
                s_axil_rresp[int'(grant_q)*2 +: 2]                   = m_axil_rresp;
                m_axil_rready                                        = s_axil_rready[grant_q];
                if (m_axil_rvalid && s_axil_rready[grant_q]) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
`endif
            end
`ifdef AXIL_RD_ARB_TIMEOUT_EN
            ST_DRAIN: begin
                m_axil_rready = 1'b1;
                if (m_axil_rvalid) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IW'(S_COUNT - 1);
            grant_q      <= '0;
            araddr_q     <= '0;
            arprot_q     <= '0;
            arvalid_q    <= 1'b0;
`ifdef AXIL_RD_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            timed_out_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            araddr_q     <= araddr_d;
            arprot_q     <= arprot_d;
            arvalid_q    <= arvalid_d;
`ifdef AXIL_RD_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
            timed_out_q  <= timed_out_d;
`endif
        end
    end

endmodule

`default_nettype wire
